// File: rtl/sigmoid_lut_pipe_if.sv
// Streaming handshake bundle for the sigmoid LUT pipeline.
// master = producer/consumer side, slave = the pipeline.
interface sigmoid_lut_pipe_if #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N_IN-1:0]  in_data;
  logic [N_OUT-1:0] in_rand;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] out_prob;
  logic             out_spin;

  modport master (
    output in_valid, in_data, in_rand, out_ready,
    input  in_ready, out_valid, out_prob, out_spin
  );

  modport slave (
    input  in_valid, in_data, in_rand, out_ready,
    output in_ready, out_valid, out_prob, out_spin
  );
endinterface

// File: rtl/sigmoid_lut_pipe.sv
// Table-driven sigmoid with Bernoulli sampling, 2-stage pipeline.
// Table is loaded through the cfg port; reload drains old results first.
module sigmoid_lut_pipe #(
  parameter int N_IN  = 8,
  parameter int P_IN  = 4,
  parameter int N_OUT = 16,
  parameter int P_OUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_we,
  input  logic [N_IN-1:0]  cfg_addr,
  input  logic [N_OUT-1:0] cfg_data,
  input  logic             cfg_done,
  output logic             cfg_err,
  output logic [1:0]       state_o,
  sigmoid_lut_pipe_if.slave io
);

  if (P_OUT != N_OUT - 1) begin : g_pout_warn
    $warning("sigmoid_lut_pipe: P_OUT=%0d, N_OUT=%0d", P_OUT, N_OUT);
  end

  if (P_IN < 0 || P_IN > N_IN) begin : g_pin_warn
    $warning("sigmoid_lut_pipe: P_IN=%0d, N_IN=%0d", P_IN, N_IN);
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic             s1_vld_q, s1_vld_d;
  logic [N_IN-1:0]  s1_data_q, s1_data_d;
  logic [N_OUT-1:0] s1_rand_q, s1_rand_d;
  logic             s2_vld_q, s2_vld_d;
  logic [N_OUT-1:0] prob_q, prob_d;
  logic             spin_q, spin_d;
  logic             err_q, err_d;

  logic             adv;
  logic             acc;
  logic             pipe_empty;
  logic             tbl_we;
  logic [N_OUT-1:0] lut_rd;

  logic [N_OUT-1:0] mem_q [0:(1<<N_IN)-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (cfg_start)  state_d = LOAD;
      LOAD:  if (cfg_done)   state_d = RUN;
      RUN:   if (cfg_start)  state_d = DRAIN;
      DRAIN: if (pipe_empty) state_d = LOAD;
      default:               state_d = EMPTY;
    endcase
  end

  always_comb begin
    state_o     = state_q;
    io.in_ready = (state_q == RUN) & adv;
    io.out_valid = s2_vld_q;
    io.out_prob  = prob_q;
    io.out_spin  = spin_q;
    cfg_err      = err_q;
  end

  // Stage 2 stalls only when it holds a result nobody takes.
  always_comb begin
    adv        = !s2_vld_q | io.out_ready;
    acc        = io.in_valid & io.in_ready;
    pipe_empty = !s1_vld_q & !s2_vld_q;
    tbl_we     = cfg_we & (state_q == LOAD);
    lut_rd     = mem_q[s1_data_q];

    s1_vld_d  = s1_vld_q;
    s1_data_d = s1_data_q;
    s1_rand_d = s1_rand_q;
    s2_vld_d  = s2_vld_q;
    prob_d    = prob_q;
    spin_d    = spin_q;

    if (adv) begin
      s1_vld_d = acc;
      s2_vld_d = s1_vld_q;
    end
    if (acc) begin
      s1_data_d = io.in_data;
      s1_rand_d = io.in_rand;
    end
    if (adv && s1_vld_q) begin
      prob_d = lut_rd;
      spin_d = s1_rand_q < lut_rd;
    end

    err_d = err_q | (cfg_we & (state_q != LOAD));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_rand_q <= '0;
      s2_vld_q  <= 1'b0;
      prob_q    <= '0;
      spin_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_data_q <= s1_data_d;
      s1_rand_q <= s1_rand_d;
      s2_vld_q  <= s2_vld_d;
      prob_q    <= prob_d;
      spin_q    <= spin_d;
      err_q     <= err_d;
    end
  end

  // Table survives reset on purpose; only a LOAD can change it.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      mem_q[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_sigmoid_lut_pipe.sv
// Self-checking bench for sigmoid_lut_pipe.
// Reference: table array plus an in-order queue of expected results.
module tb_sigmoid_lut_pipe;

  localparam int N_IN  = 8;
  localparam int N_OUT = 16;

  typedef struct packed {
    logic [15:0] prob;
    logic        spin;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_start;
  logic        cfg_we;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_done;
  logic        cfg_err;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_tbl [256];
  res_t        expq [$];

  always #5 clk = ~clk;

  sigmoid_lut_pipe_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bus ();

  sigmoid_lut_pipe #(
    .N_IN (N_IN),
    .P_IN (4),
    .N_OUT(N_OUT),
    .P_OUT(15)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .state_o  (state_o),
    .io       (bus.slave)
  );

  function automatic res_t predict(logic [7:0] x, logic [15:0] r);
    res_t e;
    e.prob = model_tbl[x];
    e.spin = (r < model_tbl[x]);
    return e;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_table(input bit rnd);
    for (int i = 0; i < 256; i++) begin
      tick();
      cfg_we   = 1'b1;
      cfg_addr = 8'(i);
      cfg_data = rnd ? 16'($urandom) : 16'(i * 256);
      cfg_done = (i == 255);
      model_tbl[i] = cfg_data;
    end
    tick();
    cfg_we   = 1'b0;
    cfg_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    checks += 6;
    if (state_o !== 2'd0) begin
      errors++; $display("FAIL rst_state got %0d exp 0", state_o);
    end
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_ovalid got %b exp 0", bus.out_valid);
    end
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_iready got %b exp 0", bus.in_ready);
    end
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL rst_err got %b exp 0", cfg_err);
    end
    if (bus.out_prob !== 16'h0) begin
      errors++; $display("FAIL rst_prob got %h exp 0", bus.out_prob);
    end
    if (bus.out_spin !== 1'b0) begin
      errors++; $display("FAIL rst_spin got %b exp 0", bus.out_spin);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      bus.in_data = 8'($urandom);
      tick();
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
          state_o !== 2'd0) begin
        errors++;
        $display("FAIL noload rdy=%b ov=%b st=%0d exp 0/0/0",
                 bus.in_ready, bus.out_valid, state_o);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_load_basic();
    logic [15:0] rv [2];
    logic        sp [2];
    rv[0] = 16'h0FFF; sp[0] = 1'b1;
    rv[1] = 16'h1000; sp[1] = 1'b0;
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd1) begin
      errors++; $display("FAIL enter_load got %0d exp 1", state_o);
    end
    load_table(1'b0);
    #1;
    checks++;
    if (state_o !== 2'd2) begin
      errors++; $display("FAIL enter_run got %0d exp 2", state_o);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 8'h10;
      bus.in_rand   = rv[k];
      #1;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL run_ready got %b exp 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL lat_early got %b exp 0", bus.out_valid);
      end
      tick();
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_prob !== 16'h1000 ||
          bus.out_spin !== sp[k]) begin
        errors++;
        $display("FAIL basic%0d v=%b p=%h s=%b exp 1/1000/%b",
                 k, bus.out_valid, bus.out_prob, bus.out_spin, sp[k]);
      end
    end
  endtask

  task automatic test_stall_stream();
    int pat [4];
    int sent = 0;
    int got  = 0;
    pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
    expq.delete();
    for (int c = 0; c < 80 && got < 8; c++) begin
      tick();
      bus.out_ready = (pat[c % 4] != 0);
      bus.in_valid  = (sent < 8);
      bus.in_data   = 8'(8'h80 + sent);
      bus.in_rand   = 16'($urandom);
      #1;
      if (bus.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL stall_extra got %h exp none", bus.out_prob);
        end else if (bus.out_prob !== expq[0].prob ||
                     bus.out_spin !== expq[0].spin) begin
          errors++;
          $display("FAIL stall_out got %h/%b exp %h/%b", bus.out_prob,
                   bus.out_spin, expq[0].prob, expq[0].spin);
        end
        if (bus.out_ready && expq.size() != 0) begin
          void'(expq.pop_front());
          got++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(predict(bus.in_data, bus.in_rand));
        sent++;
      end
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got != 8 || expq.size() != 0) begin
      errors++; $display("FAIL stall_count got %0d exp 8", got);
    end
  endtask

  task automatic test_cfg_err();
    #1;
    checks++;
    if (cfg_err !== 1'b0) begin
      errors++; $display("FAIL err_pre got %b exp 0", cfg_err);
    end
    tick();
    cfg_we   = 1'b1;
    cfg_addr = 8'h10;
    cfg_data = 16'hDEAD;
    tick();
    cfg_we = 1'b0;
    #1;
    checks++;
    if (cfg_err !== 1'b1 || state_o !== 2'd2) begin
      errors++;
      $display("FAIL err_set got %b/%0d exp 1/2", cfg_err, state_o);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h10;
    bus.in_rand   = 16'hFFFF;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_prob !== 16'h1000 ||
        bus.out_spin !== 1'b0) begin
      errors++;
      $display("FAIL err_tbl got %b/%h/%b exp 1/1000/0",
               bus.out_valid, bus.out_prob, bus.out_spin);
    end
  endtask

  task automatic test_drain();
    res_t e2 [2];
    int   k = 0;
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h20;
    bus.in_rand   = 16'($urandom);
    e2[0] = predict(bus.in_data, bus.in_rand);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL drn_acc0 got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_data = 8'h21;
    bus.in_rand = 16'($urandom);
    cfg_start   = 1'b1;
    e2[1] = predict(bus.in_data, bus.in_rand);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL drn_acc1 got %b exp 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    cfg_start    = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      #1;
      checks++;
      if (state_o !== 2'd3 || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1 || bus.out_prob !== e2[0].prob) begin
        errors++;
        $display("FAIL drn_hold st=%0d r=%b v=%b p=%h exp 3/0/1/%h",
                 state_o, bus.in_ready, bus.out_valid, bus.out_prob,
                 e2[0].prob);
      end
    end
    tick();
    bus.out_ready = 1'b1;
    #1;
    for (int c = 0; c < 10 && k < 2; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0) begin
        errors++; $display("FAIL drn_rdy got %b exp 0", bus.in_ready);
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.out_prob !== e2[k].prob || bus.out_spin !== e2[k].spin) begin
          errors++;
          $display("FAIL drn_res%0d got %h/%b exp %h/%b", k, bus.out_prob,
                   bus.out_spin, e2[k].prob, e2[k].spin);
        end
        k++;
      end
      tick();
      #1;
    end
    checks++;
    if (k != 2) begin
      errors++; $display("FAIL drn_count got %0d exp 2", k);
    end
    for (int c = 0; c < 10 && state_o != 2'd1; c++) begin
      tick();
      #1;
    end
    checks++;
    if (state_o !== 2'd1) begin
      errors++; $display("FAIL drn_load got %0d exp 1", state_o);
    end
  endtask

  task automatic test_random();
    load_table(1'b1);
    #1;
    checks++;
    if (state_o !== 2'd2) begin
      errors++; $display("FAIL rnd_run got %0d exp 2", state_o);
    end
    expq.delete();
    for (int c = 0; c < 600; c++) begin
      tick();
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data   = 8'($urandom);
      case (c % 6)
        0: bus.in_rand = model_tbl[bus.in_data];
        1: bus.in_rand = model_tbl[bus.in_data] - 16'd1;
        2: bus.in_rand = 16'hFFFF;
        3: bus.in_rand = 16'h0000;
        default: bus.in_rand = 16'($urandom);
      endcase
      #1;
      checks++;
      if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
        errors++;
        $display("FAIL rnd_rdy got %b ov=%b or=%b", bus.in_ready,
                 bus.out_valid, bus.out_ready);
      end
      if (bus.out_valid) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL rnd_extra got %h exp none", bus.out_prob);
        end else if (bus.out_prob !== expq[0].prob ||
                     bus.out_spin !== expq[0].spin) begin
          errors++;
          $display("FAIL rnd_out got %h/%b exp %h/%b", bus.out_prob,
                   bus.out_spin, expq[0].prob, expq[0].spin);
        end
        if (bus.out_ready && expq.size() != 0) void'(expq.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(predict(bus.in_data, bus.in_rand));
      end
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && expq.size() != 0; c++) begin
      #1;
      if (bus.out_valid) begin
        checks++;
        if (bus.out_prob !== expq[0].prob || bus.out_spin !== expq[0].spin)
        begin
          errors++;
          $display("FAIL rnd_tail got %h/%b exp %h/%b", bus.out_prob,
                   bus.out_spin, expq[0].prob, expq[0].spin);
        end
        void'(expq.pop_front());
      end
      tick();
    end
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL rnd_lost got %0d left exp 0", expq.size());
    end
  endtask

  task automatic test_reset_mid();
    tick();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.in_rand   = 16'h0000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++; $display("FAIL rm_pre got %b exp 1", bus.out_valid);
    end
    rst_n = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || state_o !== 2'd0 || cfg_err !== 1'b0 ||
        bus.out_prob !== 16'h0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rm_post v=%b st=%0d e=%b p=%h r=%b exp 0/0/0/0/0",
               bus.out_valid, state_o, cfg_err, bus.out_prob, bus.in_ready);
    end
    rst_n = 1'b1;
    tick();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_done  = 1'b1;
    tick();
    cfg_done = 1'b0;
    #1;
    checks++;
    if (state_o !== 2'd2 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rm_reload st=%0d v=%b exp 2/0", state_o, bus.out_valid);
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.in_rand   = 16'h0000;
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_prob !== model_tbl[8'h55]) begin
      errors++;
      $display("FAIL rm_keep got %b/%h exp 1/%h", bus.out_valid,
               bus.out_prob, model_tbl[8'h55]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    cfg_start     = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = 8'h00;
    cfg_data      = 16'h0000;
    cfg_done      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_rand   = 16'h0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_load_basic();
    test_stall_stream();
    test_cfg_err();
    test_drain();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
